// File: rtl/alu.sv
// Registered ALU: bitwise ops, add/sub, multiply, compare and one-bit shift on SIZE-bit
// operands. The result and flag register one cycle after an enabled edge.
module alu #(
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [3:0]        command,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              overflow,
    output logic [2*SIZE-1:0] result
);

    localparam int W2 = 2 * SIZE;

    localparam logic [3:0] CMD_AND   = 4'h0;
    localparam logic [3:0] CMD_OR    = 4'h1;
    localparam logic [3:0] CMD_XOR   = 4'h2;
    localparam logic [3:0] CMD_NOT   = 4'h3;
    localparam logic [3:0] CMD_ADDU  = 4'h4;
    localparam logic [3:0] CMD_ADDS  = 4'h5;
    localparam logic [3:0] CMD_SUBU  = 4'h6;
    localparam logic [3:0] CMD_SUBS  = 4'h7;
    localparam logic [3:0] CMD_MULU  = 4'h8;
    localparam logic [3:0] CMD_MULS  = 4'h9;
    localparam logic [3:0] CMD_CMPU  = 4'hA;
    localparam logic [3:0] CMD_CMPS  = 4'hB;
    localparam logic [3:0] CMD_SHIFT = 4'hC;

    logic [W2-1:0]   result_q, result_d;
    logic            overflow_q, overflow_d;

    logic [SIZE:0]   sum_u;
    logic [SIZE-1:0] diff;
    logic [W2-1:0]   prod_u;
    logic [W2-1:0]   prod_s;
    logic [SIZE-1:0] narrow;
    logic [W2-1:0]   wide;
    logic            use_wide;
    logic            prod_s_fits;

    assign sum_u  = {1'b0, a} + {1'b0, b};
    assign diff   = a - b;
    assign prod_u = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    // Sign-extending both operands makes the low W2 bits of the plain product the signed product.
    assign prod_s = {{SIZE{a[SIZE-1]}}, a} * {{SIZE{b[SIZE-1]}}, b};
    assign prod_s_fits = (&prod_s[W2-1:SIZE-1]) || !(|prod_s[W2-1:SIZE-1]);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        narrow     = '0;
        wide       = '0;
        use_wide   = 1'b0;
        overflow_d = 1'b0;
        case (command)
            CMD_AND:  narrow = a & b;
            CMD_OR:   narrow = a | b;
            CMD_XOR:  narrow = a ^ b;
            CMD_NOT:  narrow = ~a;
            CMD_ADDU: begin
                narrow     = sum_u[SIZE-1:0];
                overflow_d = sum_u[SIZE];
            end
            CMD_ADDS: begin
                narrow     = sum_u[SIZE-1:0];
                overflow_d = (a[SIZE-1] == b[SIZE-1]) && (sum_u[SIZE-1] != a[SIZE-1]);
            end
            CMD_SUBU: narrow = diff;
            CMD_SUBS: begin
                narrow     = diff;
                overflow_d = (a[SIZE-1] != b[SIZE-1]) && (diff[SIZE-1] != a[SIZE-1]);
            end
            CMD_MULU: begin
                // Result MSB is dropped: the product is taken modulo 2^(W2-1).
                wide       = {1'b0, prod_u[W2-2:0]};
                use_wide   = 1'b1;
                overflow_d = |prod_u[W2-1:SIZE];
            end
            CMD_MULS: begin
                narrow     = prod_s[SIZE-1:0];
                overflow_d = !prod_s_fits;
            end
            CMD_CMPU: begin
                if (a == b)     narrow = SIZE'(2);
                else if (a > b) narrow = SIZE'(1);
            end
            CMD_CMPS: begin
                if (a == b)                      narrow = SIZE'(2);
                else if ($signed(a) > $signed(b)) narrow = SIZE'(1);
            end
            CMD_SHIFT: narrow = b[0] ? {a[SIZE-2:0], b[1]} : {b[1], a[SIZE-1:1]};
            default: ;
        endcase
        result_d = use_wide ? wide : {{SIZE{1'b0}}, narrow};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else if (enable) begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed expectations, the monitor
// pops one per clock after the edge and compares against the registered outputs.
`timescale 1ns/1ps
module tb_alu;

    typedef struct {
        int          idx;
        logic [3:0]  cmd;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [7:0]  res;
        logic        ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] command;
    logic [3:0] a;
    logic [3:0] b;
    logic       overflow;
    logic [7:0] result;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;

    alu #(.SIZE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .command  (command),
        .a        (a),
        .b        (b),
        .overflow (overflow),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge and queue what the outputs must show after the next rising edge.
    task automatic drive(input logic r, input logic en, input logic [3:0] c,
                         input logic [3:0] va, input logic [3:0] vb,
                         input logic [7:0] er, input logic eo);
        exp_t e;
        @(negedge clk);
        rst     = r;
        enable  = en;
        command = c;
        a       = va;
        b       = vb;
        e.idx = n_vec; e.cmd = c; e.a = va; e.b = vb; e.res = er; e.ov = eo;
        exp_q.push_back(e);
        n_vec++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (result !== e.res || overflow !== e.ov) begin
                    n_bad++;
                    $display("FAIL vec%0d cmd=%h a=%h b=%h: got result=%h overflow=%b, want result=%h overflow=%b",
                             e.idx, e.cmd, e.a, e.b, result, overflow, e.res, e.ov);
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        rst = 1'b0; enable = 1'b0; command = 4'h0; a = 4'h0; b = 4'h0;

        //     rst   en    cmd   a     b     result  ov
        drive(1'b1, 1'b0, 4'h4, 4'hF, 4'h1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 4'h4, 4'hF, 4'h1, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 4'h4, 4'h7, 4'h1, 8'h08, 1'b0);
        drive(1'b0, 1'b1, 4'h5, 4'h7, 4'h1, 8'h08, 1'b1);
        drive(1'b0, 1'b1, 4'h5, 4'h8, 4'hF, 8'h07, 1'b1);
        drive(1'b0, 1'b1, 4'h5, 4'hF, 4'h1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 4'h6, 4'h3, 4'h5, 8'h0E, 1'b0);
        drive(1'b0, 1'b1, 4'h7, 4'h8, 4'h1, 8'h07, 1'b1);
        drive(1'b0, 1'b1, 4'h7, 4'h7, 4'hF, 8'h08, 1'b1);
        drive(1'b0, 1'b1, 4'h7, 4'h5, 4'h3, 8'h02, 1'b0);
        drive(1'b0, 1'b1, 4'h0, 4'hC, 4'hA, 8'h08, 1'b0);
        drive(1'b0, 1'b1, 4'h1, 4'hC, 4'hA, 8'h0E, 1'b0);
        drive(1'b0, 1'b1, 4'h2, 4'hC, 4'hA, 8'h06, 1'b0);
        drive(1'b0, 1'b1, 4'h3, 4'h5, 4'hF, 8'h0A, 1'b0);
        drive(1'b0, 1'b1, 4'h8, 4'h7, 4'h8, 8'h38, 1'b1);
        drive(1'b0, 1'b1, 4'h8, 4'hF, 4'hF, 8'h61, 1'b1);
        drive(1'b0, 1'b1, 4'h8, 4'h3, 4'h2, 8'h06, 1'b0);
        drive(1'b0, 1'b1, 4'hD, 4'h5, 4'h5, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 4'h9, 4'hE, 4'hB, 8'h0A, 1'b1);
        drive(1'b0, 1'b1, 4'h9, 4'hF, 4'h2, 8'h0E, 1'b0);
        drive(1'b0, 1'b1, 4'h9, 4'hF, 4'hF, 8'h01, 1'b0);
        drive(1'b0, 1'b1, 4'hB, 4'hF, 4'h0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 4'hB, 4'h0, 4'hF, 8'h01, 1'b0);
        drive(1'b0, 1'b1, 4'hB, 4'h0, 4'h0, 8'h02, 1'b0);
        drive(1'b0, 1'b1, 4'hA, 4'hF, 4'h0, 8'h01, 1'b0);
        drive(1'b0, 1'b1, 4'hA, 4'h3, 4'h5, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 4'hC, 4'h9, 4'h2, 8'h0C, 1'b0);
        drive(1'b0, 1'b1, 4'hC, 4'h9, 4'h0, 8'h04, 1'b0);
        drive(1'b0, 1'b1, 4'hC, 4'h1, 4'h3, 8'h03, 1'b0);
        drive(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 8'h00, 1'b0);
        // Load a non-zero result with overflow set, then hold it with enable low.
        drive(1'b0, 1'b1, 4'h8, 4'hF, 4'hF, 8'h61, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h61, 1'b1);
        drive(1'b0, 1'b0, 4'h4, 4'hF, 4'hF, 8'h61, 1'b1);
        drive(1'b0, 1'b0, 4'hD, 4'h2, 4'h9, 8'h61, 1'b1);
        // Reset wins over enable, then the first enabled edge updates again.
        drive(1'b1, 1'b1, 4'h8, 4'hF, 4'hF, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 4'h8, 4'hF, 4'hF, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 4'h4, 4'h7, 4'h1, 8'h08, 1'b0);

        @(negedge clk);
        enable = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: SIZE, default 4, operand width in bits; result width is 2*SIZE.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: enable  input  1  when high, the operation is evaluated and registered on the clock edge.
REQ-005 Port: command  input  4  opcode select.
REQ-006 Port: a  input  SIZE  operand A.
REQ-007 Port: b  input  SIZE  operand B.
REQ-008 Port: overflow  output  1  registered overflow/carry flag.
REQ-009 Port: result  output  2*SIZE  registered result.
REQ-010 Port order SHALL be clk, rst, enable, command, a, b, overflow, result, so that positional instantiation works.

Function
REQ-011 result and overflow SHALL be registered outputs with one-cycle latency: inputs sampled at edge N appear at the outputs after edge N.
REQ-012 With enable=0 and rst=0, result and overflow SHALL hold their previous values.
REQ-013 Unless stated otherwise, result SHALL be the SIZE-bit value zero-extended to 2*SIZE bits, with the upper bits forced to 0 and no sign extension.
REQ-014 0x0 AND: a&b; overflow=0.
REQ-015 0x1 OR: a|b; overflow=0.
REQ-016 0x2 XOR: a^b; overflow=0.
REQ-017 0x3 NOT: ~a (SIZE bits), b ignored; overflow=0.
REQ-018 0x4 unsigned add: (a+b) mod 2^SIZE; overflow = carry out of bit SIZE-1.
REQ-019 0x5 signed add: (a+b) mod 2^SIZE; overflow=1 when a and b have equal sign bits and the sum's sign bit differs.
REQ-020 0x6 unsigned subtract: (a-b) mod 2^SIZE; overflow SHALL always be 0, including when a<b.
REQ-021 0x7 signed subtract: (a-b) mod 2^SIZE; overflow=1 when a and b sign bits differ and the result's sign bit differs from a's.
REQ-022 0x8 unsigned multiply: result = (a*b) mod 2^(2*SIZE-1), so the result MSB is always 0; overflow=1 when a*b >= 2^SIZE.
REQ-023 0x9 signed multiply: result = low SIZE bits of the two's-complement product, zero-extended; overflow=1 when the product lies outside [-2^(SIZE-1), 2^(SIZE-1)-1].
REQ-024 0xA unsigned compare: result=2 if a==b, 1 if a>b, 0 if a<b; overflow=0.
REQ-025 0xB signed compare: same encoding as 0xA, with a and b treated as two's complement; overflow=0.
REQ-026 0xC shift by one bit, with direction and fill taken from b:
  - b[0]=1: shift a left; b[1] fills bit 0.
  - b[0]=0: shift a right; b[1] fills bit SIZE-1.
  - Result is SIZE bits; the shifted-out bit is discarded; overflow=0.
REQ-027 0xD-0xF reserved: result=0, overflow=0 (registered when enable=1).
REQ-028 All operations SHALL be computed combinationally from the current a, b and command, with no multi-cycle operations.

Reset
REQ-029 When rst=1 at a rising clk edge, result SHALL become 0 and overflow 0, regardless of enable or command.
REQ-030 rst SHALL take priority over enable; after reset deassertion the outputs update from the first enabled edge.

Verification
REQ-031 Reset, then enable=1, cmd=0x4, a=F, b=1 -> next cycle result=0x00, overflow=1; then a=7, b=1 -> result=0x08, overflow=0.
REQ-032 cmd=0x5: a=7, b=1 -> 0x08, overflow=1; a=8, b=F -> 0x07, overflow=1; a=F, b=1 -> 0x00, overflow=0.
REQ-033 cmd=0x8: a=7, b=8 -> 0x38, overflow=1; a=F, b=F -> 0x61, overflow=1; a=3, b=2 -> 0x06, overflow=0.
REQ-034 cmd=0x9: a=E, b=B -> 0x0A, overflow=1; a=F, b=2 -> 0x0E, overflow=0; a=F, b=F -> 0x01, overflow=0.
REQ-035 Compare and shift:
  - cmd=0xB: a=F, b=0 -> 0; a=0, b=F -> 1; a=0, b=0 -> 2.
  - cmd=0xA: a=F, b=0 -> 1.
  - cmd=0xC: a=9, b=2 -> 0x0C; a=9, b=0 -> 0x04; a=1, b=3 -> 0x03.
REQ-036 Hold and reset: set enable=0 and change a, b, command -> outputs unchanged; assert rst with enable=1 -> result=0 and overflow=0 on the next edge.
